uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer directly downstream of the UART receiver. It captures each byte the receiver completes and queues it in a first-word-fall-through FIFO. The FIFO is drained through a valid/ready interface. Overruns are flagged stickily, and an optional character-timeout flag tells the host when a partial burst is waiting.

Parameters:
- DBITS, 8, width of one received byte; must match the receiver's data width.
- DEPTH, 16, number of FIFO entries; must be a power of two, at least 2.
- TIMEOUT_TICKS, 640, number of oversample ticks with no FIFO activity before rx_timeout asserts (4 frames × 10 bits × 16 samples). Used only with the optional feature.

Ports:
- clk, in, 1, single system clock; every flop is clocked on its rising edge.
- rst_n, in, 1, synchronous active-low reset, sampled on the rising edge of clk.
- tick, in, 1, oversample tick from the baud generator; the same tick the receiver uses.
- rx_done, in, 1, one-cycle strobe from the receiver marking that din is valid.
- din, in, DBITS, received byte; sampled only while rx_done=1.
- rd_valid, out, 1, FIFO not empty; rd_data holds the head entry.
- rd_ready, in, 1, consumer accepts the head entry when rd_valid=1.
- rd_data, out, DBITS, head entry, shown fall-through.
- count, out, $clog2(DEPTH+1), current number of stored entries.
- full, out, 1, count == DEPTH.
- overrun, out, 1, sticky: a byte was dropped because the FIFO was full.
- ovr_clr, in, 1, clears overrun.
- rx_timeout, out, 1, character timeout; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Pointers, count, overrun, rx_timeout and the timeout counter all go to 0.
  - rd_valid=0 and full=0.
  - rd_data is don't-care while rd_valid=0.
  - Reset overrides every other input, including an in-flight rx_done or a pop in progress.
- Write:
  - On an edge with rx_done=1 and (!full or pop), din goes to mem[wptr] and wptr increments modulo DEPTH.
  - rd_valid and count reflect the write in the cycle after the edge. Write-to-read latency is 1 cycle.
- Pop:
  - pop = rd_valid & rd_ready. On the edge, rptr increments modulo DEPTH.
  - rd_data updates combinationally from mem[rptr]; no read latency.
- Count update:
  - count += write_accepted − pop.
  - Simultaneous write and pop leaves count unchanged.
- Boundary conditions:
  - Full with rx_done and no pop: the byte is dropped, overrun is set on that edge, and FIFO contents are unchanged.
  - Full with rx_done and pop in the same cycle: the write is accepted and there is no overrun.
  - Empty with rx_done: the byte is not popped that cycle, because rd_valid was 0.
  - rd_ready while empty is ignored; pointers are unchanged.
- overrun clearing:
  - Cleared by ovr_clr.
  - If ovr_clr and a new drop happen in the same cycle, set wins and overrun stays 1.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. full and empty are derived from count, not from pointer comparison.
- Back-to-back strobes: rx_done is high for at most one cycle per byte. A strobe on every cycle must still be handled correctly (bench stress).

Optional Feature:
- Macro: UART_RX_FIFO_TIMEOUT_EN.
- Enabled:
  - A tick counter, $clog2(TIMEOUT_TICKS+1) bits wide, increments on tick while count≠0 and rx_timeout=0.
  - The counter resets to 0 on any accepted write, any pop, or when count==0.
  - When the counter reaches TIMEOUT_TICKS, rx_timeout is set on that edge.
  - rx_timeout clears on the next accepted write, the next pop, or reset.
- Disabled:
  - No counter is built and rx_timeout is tied to 0.
  - tick is unused but the port stays, so the interface is identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - UART_DBITS=8, UART_SAMPLE=16 and UART_FRAME_BITS=10.
  - A localparam function computing the default TIMEOUT_TICKS (4·FRAME_BITS·SAMPLE).
- One sub-module, uart_fifo_mem: a DEPTH×DBITS register array with synchronous write and asynchronous read. No reset on the array.
- Pointer, count, flag and timeout logic stays in uart_rx_fifo.

Test Plan:
- Reset, then rx_done with din=0xA5 → next cycle rd_valid=1, rd_data=0xA5, count=1. Pop with rd_ready=1 → rd_valid=0, count=0.
- Write 0x00..0x0F, 16 bytes at DEPTH=16 → full=1. A 17th write of 0x55 → overrun=1, contents unchanged. Drain → 0x00..0x0F in order. ovr_clr → overrun=0.
- FIFO full with rx_done=1 (din=0x77) and rd_ready=1 in the same cycle → no overrun, count stays 16, 0x77 read out last.
- Write/pop across 40 bytes so the pointers wrap twice → strict FIFO order, count never exceeds DEPTH.
- rst_n=0 while count=5 and rx_done is asserted → all outputs 0 on the next cycle. A subsequent write of 0x3C is read first.
- Timeout build with TIMEOUT_TICKS=640: write one byte, then supply 639 ticks → rx_timeout=0. At the 640th tick → rx_timeout=1. Pop → rx_timeout=0. Non-timeout build → rx_timeout stays 0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//
// Shared constants for the UART receive path.
//
// Contents:
//   UART_DBITS          - data bits per character
//   UART_SAMPLE         - oversample ticks per bit
//   UART_FRAME_BITS     - bits per frame (start + data + stop)
//   calc_timeout_ticks  - derives the character-timeout length in ticks
//   UART_TIMEOUT_TICKS  - default timeout: four idle frames
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DBITS      = 8;
  localparam int UART_SAMPLE     = 16;
  localparam int UART_FRAME_BITS = 10;

  // A partial burst is reported after four frame-times with no FIFO activity.
  // The result is measured in oversample ticks.
  function automatic int calc_timeout_ticks(input int frame_bits,
                                            input int sample);
    return 4 * frame_bits * sample;
  endfunction

  localparam int UART_TIMEOUT_TICKS = calc_timeout_ticks(UART_FRAME_BITS,
                                                         UART_SAMPLE);

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// ----------------------------------------------------------------------------
// uart_fifo_mem
//
// DEPTH x DBITS register array. Writes are synchronous. Reads are
// asynchronous, so the addressed word appears in the same cycle. The array
// has no reset: the owner qualifies every read with its own valid state.
//
// Ports:
//   clk    in   clock; the array is written on its rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
// ----------------------------------------------------------------------------
module uart_fifo_mem #(
  parameter int DBITS = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [DBITS-1:0] rdata
);

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [DBITS-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte buffer behind the UART receiver. Each byte the receiver
// completes (rx_done strobe) is queued in a first-word-fall-through FIFO and
// drained through a valid/ready port. A dropped byte sets a sticky overrun
// flag.
//
// Build option:
//   UART_RX_FIFO_TIMEOUT_EN  when defined, a character-timeout counter drives
//                            rx_timeout. When undefined, rx_timeout is tied
//                            to 0 and tick is ignored.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   tick        in   oversample tick from the baud generator
//   rx_done     in   one-cycle strobe: din holds a received byte
//   din         in   received byte
//   rd_valid    out  FIFO not empty; rd_data holds the head entry
//   rd_ready    in   consumer accepts the head entry
//   rd_data     out  head entry, fall-through
//   count       out  number of stored entries
//   full        out  count == DEPTH
//   overrun     out  sticky: a byte was dropped while full
//   ovr_clr     in   clears overrun (a simultaneous drop wins)
//   rx_timeout  out  character timeout
//
// Read handshake: an entry transfers on a rising edge where rd_valid and
// rd_ready are both 1. rd_valid does not depend on rd_ready. rd_data stays
// stable while rd_valid=1 and no transfer occurs. rd_ready with rd_valid=0
// has no effect.
// ----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DBITS         = UART_DBITS,
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = UART_TIMEOUT_TICKS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       rx_done,
  input  logic [DBITS-1:0]           din,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DBITS-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overrun,
  input  logic                       ovr_clr,
  output logic                       rx_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;

  logic pop;
  logic wr_accept;
  logic drop;
  logic mem_we;

  // Occupancy comes from the counter alone. Pointers wrap freely, so
  // comparing them could not tell full from empty.
  assign rd_valid = (count_q != '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overrun  = overrun_q;

  assign pop = rd_valid & rd_ready;

  // A pop in the same cycle frees the head slot, so a full FIFO can still
  // take the incoming byte.
  assign wr_accept = rx_done & (~full | pop);
  assign drop      = rx_done & full & ~pop;

  // Hold the array during reset so a strobe in that cycle leaves no trace.
  assign mem_we = wr_accept & rst_n;

  uart_fifo_mem #(
    .DBITS (DBITS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_q),
    .wdata (din),
    .raddr (rptr_q),
    .rdata (rd_data)
  );

  // Pointers, occupancy and the overrun flag.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (wr_accept) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end

    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new drop takes priority over a clear in the same cycle.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  // Character timeout: count ticks while data is waiting and nothing moves.
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rx_timeout_q, rx_timeout_d;

  always_comb begin
    tmo_cnt_d    = tmo_cnt_q;
    rx_timeout_d = rx_timeout_q;

    if (wr_accept || pop || (count_q == '0)) begin
      tmo_cnt_d = '0;
    end else if (tick && !rx_timeout_q) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
      // The flag rises on the same edge where the counter reaches the limit.
      if (tmo_cnt_q == TW'(TIMEOUT_TICKS - 1)) begin
        rx_timeout_d = 1'b1;
      end
    end

    // Any FIFO activity means the host is engaged again.
    if (wr_accept || pop) begin
      rx_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q    <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  assign rx_timeout = rx_timeout_q;
`else
  // The timeout is not built. tick and TIMEOUT_TICKS remain on the interface
  // so both builds present the same ports and parameters.
  logic        unused_tick;
  logic [31:0] unused_timeout_ticks;

  assign unused_tick          = tick;
  assign unused_timeout_ticks = 32'(TIMEOUT_TICKS);
  assign rx_timeout           = 1'b0;
`endif

endmodule : uart_rx_fifo
